// File: rtl/io_port_unit.sv
// Memory-mapped I/O stage: output port 0xFE, debounced input port 0xFF,
// and the CPU read-data multiplexer behind the address decoder.
module io_port_unit #(
    parameter int unsigned          DATA_W          = 8,
    parameter int unsigned          DEBOUNCE_CYCLES = 4,
    parameter logic [DATA_W-1:0]    OPORT_RESET     = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_oport0,
    input  logic              we_iport0,
    input  logic              sel_ram_io,
    input  logic              sel_o_i,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    input  logic [DATA_W-1:0] iport0_pin,
    output logic [DATA_W-1:0] oport0,
    output logic [DATA_W-1:0] rdata,
    output logic              iport0_changed
);

    localparam int unsigned CNT_W =
        (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [DATA_W-1:0] r_oport;
    logic [DATA_W-1:0] r_s1;
    logic [DATA_W-1:0] r_s2;
    logic [DATA_W-1:0] r_s3;
    logic [DATA_W-1:0] r_stable;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_changed;

    logic              w_same;
    logic              w_moving;
    logic              w_accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_oport <= OPORT_RESET;
        end else if (we_oport0) begin
            r_oport <= wdata;
        end
    end

    // s1/s2 resolve metastability; s3 lets us see whether s2 is still moving.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= '0;
            r_s2 <= '0;
            r_s3 <= '0;
        end else begin
            r_s1 <= iport0_pin;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign w_same   = (r_s2 == r_stable);
    assign w_moving = (r_s2 != r_s3);
    assign w_accept = !w_same && !w_moving && (r_cnt == CNT_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_stable <= '0;
        end else if (w_same || w_moving) begin
            r_cnt    <= '0;
        end else if (w_accept) begin
            r_cnt    <= '0;
            r_stable <= r_s2;
        end else begin
            r_cnt    <= r_cnt + 1'b1;
        end
    end

    // A fresh update outranks an acknowledge in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_changed <= 1'b0;
        end else if (w_accept) begin
            r_changed <= 1'b1;
        end else if (we_iport0) begin
            r_changed <= 1'b0;
        end
    end

    always_comb begin
        rdata = ram_rdata;
        if (sel_ram_io) begin
            rdata = sel_o_i ? r_stable : r_oport;
        end
    end

    assign oport0         = r_oport;
    assign iport0_changed = r_changed;

endmodule

// File: tb/tb_io_port_unit.sv
// Directed bench for io_port_unit: table-driven port/read-mux vectors
// plus hand-written debounce, acknowledge and reset sequences.
module tb_io_port_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       we_oport0, we_iport0, sel_ram_io, sel_o_i;
    logic [7:0] wdata, ram_rdata, iport0_pin, oport0, rdata;
    logic       iport0_changed;

    int total = 0;
    int bad   = 0;

    io_port_unit #(
        .DATA_W(8), .DEBOUNCE_CYCLES(4), .OPORT_RESET(8'h00)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .we_oport0(we_oport0), .we_iport0(we_iport0),
        .sel_ram_io(sel_ram_io), .sel_o_i(sel_o_i),
        .wdata(wdata), .ram_rdata(ram_rdata), .iport0_pin(iport0_pin),
        .oport0(oport0), .rdata(rdata), .iport0_changed(iport0_changed)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       we;
        logic [7:0] wd;
        logic       sio;
        logic       soi;
        logic [7:0] ram;
        logic [7:0] exp_rdata;
        logic [7:0] exp_oport;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [7:0] act,
                       input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_in();
        sel_ram_io = 1'b1;
        sel_o_i    = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; we_oport0 = 0; we_iport0 = 0;
        sel_ram_io = 1; sel_o_i = 1;
        wdata = 0; ram_rdata = 0; iport0_pin = 0;

        vecs[0] = '{1, 8'hA5, 1, 0, 8'h00, 8'h00, 8'hA5};
        vecs[1] = '{0, 8'hFF, 1, 0, 8'h00, 8'hA5, 8'hA5};
        vecs[2] = '{0, 8'h00, 0, 0, 8'h3C, 8'h3C, 8'hA5};
        vecs[3] = '{0, 8'h00, 0, 1, 8'hC3, 8'hC3, 8'hA5};
        vecs[4] = '{1, 8'h12, 0, 0, 8'h99, 8'h99, 8'h12};
        vecs[5] = '{0, 8'h34, 1, 1, 8'h55, 8'h00, 8'h12};
        vecs[6] = '{1, 8'h00, 1, 0, 8'h00, 8'h12, 8'h00};
        vecs[7] = '{1, 8'hFF, 1, 0, 8'h00, 8'h00, 8'hFF};

        // reset
        repeat (2) tick();
        chk("rst_oport", oport0, 8'h00);
        chk("rst_flag", {7'd0, iport0_changed}, 8'h00);
        chk("rst_rdata_in", rdata, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("post_rst_oport", oport0, 8'h00);

        // table: read mux before the edge, oport after it
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            we_oport0  = vecs[i].we;
            wdata      = vecs[i].wd;
            sel_ram_io = vecs[i].sio;
            sel_o_i    = vecs[i].soi;
            ram_rdata  = vecs[i].ram;
            #1;
            chk($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
            tick();
            chk($sformatf("vec%0d_oport", i), oport0, vecs[i].exp_oport);
        end
        @(negedge clk);
        we_oport0 = 0;
        rd_in();

        // debounce latency 00 -> 5A
        iport0_pin = 8'h5A;
        for (int e = 0; e <= 6; e++) begin
            tick();
            chk($sformatf("lat_e%0d", e), rdata, (e < 6) ? 8'h00 : 8'h5A);
            chk($sformatf("lat_flag_e%0d", e), {7'd0, iport0_changed},
                (e < 6) ? 8'h00 : 8'h01);
        end

        // acknowledge; wdata must not matter
        @(negedge clk);
        we_iport0 = 1; wdata = 8'hEE;
        tick();
        chk("ack_flag", {7'd0, iport0_changed}, 8'h00);
        chk("ack_oport", oport0, 8'hFF);
        @(negedge clk);
        we_iport0 = 0;

        // update and acknowledge on the same edge
        iport0_pin = 8'h33;
        for (int e = 0; e <= 6; e++) begin
            if (e == 6) we_iport0 = 1;
            tick();
            if (e == 5) chk("sw_pre", rdata, 8'h5A);
            @(negedge clk);
            we_iport0 = 0;
        end
        chk("sw_stable", rdata, 8'h33);
        chk("sw_flag", {7'd0, iport0_changed}, 8'h01);
        we_iport0 = 1;
        tick();
        @(negedge clk);
        we_iport0 = 0;
        chk("sw_ack", {7'd0, iport0_changed}, 8'h00);

        // glitches of 3 and 4 cycles are rejected
        for (int g = 3; g <= 4; g++) begin
            iport0_pin = 8'hFF;
            repeat (g) @(negedge clk);
            iport0_pin = 8'h33;
            repeat (6) @(negedge clk);
            chk($sformatf("gl%0d_stable", g), rdata, 8'h33);
            chk($sformatf("gl%0d_flag", g), {7'd0, iport0_changed}, 8'h00);
            chk($sformatf("gl%0d_cnt", g), {6'd0, dut.r_cnt}, 8'h00);
        end

        // toggling input never settles
        for (int t = 0; t < 20; t++) begin
            iport0_pin = t[0] ? 8'h55 : 8'hAA;
            @(negedge clk);
        end
        iport0_pin = 8'h33;
        chk("tog_stable", rdata, 8'h33);
        chk("tog_flag", {7'd0, iport0_changed}, 8'h00);
        repeat (6) @(negedge clk);
        chk("tog_settle", rdata, 8'h33);

        // reset two cycles into a debounce of 77
        we_oport0 = 1; wdata = 8'h12;
        @(negedge clk);
        we_oport0 = 0;
        iport0_pin = 8'h77;
        repeat (2) tick();
        #1;
        rst_n = 1'b0;
        #1;
        chk("mr_oport", oport0, 8'h00);
        chk("mr_flag", {7'd0, iport0_changed}, 8'h00);
        chk("mr_stable", rdata, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        for (int e = 0; e <= 6; e++) begin
            tick();
            if (e >= 5)
                chk($sformatf("mr_e%0d", e), rdata,
                    (e < 6) ? 8'h00 : 8'h77);
        end
        chk("mr_flag_set", {7'd0, iport0_changed}, 8'h01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/io_port_unit.md
Name: io_port_unit

Overview:
- Memory-mapped I/O stage directly downstream of the cdecv address decoder.
- Consumes we_oport0, we_iport0, sel_ram_io and sel_o_i, and produces the CPU read-data word.
- Holds output port 0 at 0xFE.
- Conditions external input port 0 at 0xFF through a synchroniser and a debouncer, and provides a sticky change flag.

Parameters:
- DATA_W, 8, width of data bus and ports.
- DEBOUNCE_CYCLES, 4, consecutive stable cycles required before accepting a new input value. Legal range 1..65535.
- OPORT_RESET, 8'h00, reset value of oport0.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- we_oport0  in  1  write strobe for 0xFE, from the address decoder.
- we_iport0  in  1  write strobe for 0xFF, from the address decoder. Acknowledges (clears) the change flag.
- sel_ram_io  in  1  read select: 0 selects RAM, 1 selects I/O.
- sel_o_i  in  1  I/O read select: 0 selects oport0, 1 selects input port 0.
- wdata  in  DATA_W  CPU write data.
- ram_rdata  in  DATA_W  RAM read data.
- iport0_pin  in  DATA_W  asynchronous external input pins.
- oport0  out  DATA_W  registered output port.
- rdata  out  DATA_W  read data to the CPU.
- iport0_changed  out  1  sticky flag: the debounced input has changed since the last acknowledge.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - oport0 = OPORT_RESET.
  - Sync stages s1, s2, s3 = 0.
  - Debounced value stable = 0.
  - cnt = 0.
  - iport0_changed = 0.
  - Reset asserted mid-debounce discards the pending value.
- oport0:
  - When we_oport0=1, oport0 <= wdata at the next edge. Otherwise it holds.
  - One-cycle write latency.
- Synchroniser:
  - s1 <= iport0_pin, s2 <= s1, s3 <= s2 on every edge.
  - The whole word is treated as one value. No per-bit debounce.
- Debounce, evaluated each edge in this priority order:
  - (a) If s2 == stable: cnt <= 0.
  - (b) Else if s2 != s3 (value still moving): cnt <= 0.
  - (c) Else if cnt == DEBOUNCE_CYCLES-1: stable <= s2, cnt <= 0, and the change flag is set.
  - (d) Else: cnt <= cnt+1.
  - cnt width is clog2(DEBOUNCE_CYCLES), minimum 1 bit.
  - Latency: pin value applied before edge 0 and held appears on stable after edge 2+DEBOUNCE_CYCLES.
  - A glitch shorter than DEBOUNCE_CYCLES+1 cycles never reaches stable.
  - If the input returns to stable mid-count, cnt clears and nothing is flagged.
- iport0_changed:
  - Set at the edge where stable updates.
  - Cleared at the edge where we_iport0=1.
  - Simultaneous set and clear: set wins, so the flag stays 1.
  - wdata is ignored for 0xFF writes.
- rdata (combinational, zero latency):
  - sel_ram_io=0: ram_rdata.
  - sel_ram_io=1 and sel_o_i=0: oport0 (readback).
  - sel_ram_io=1 and sel_o_i=1: stable.
  - sel_ram_io=0 with sel_o_i=1 is unreachable; rdata = ram_rdata.
- Write and read to the same address in one cycle: rdata shows the old oport0, and the new value appears after the edge.
- we_oport0 and we_iport0 are never both 1 (guaranteed by the decoder). If both are asserted, both actions occur independently.

Test Plan:
- Reset check: hold rst_n=0, then release. Required: oport0=8'h00, iport0_changed=0. With sel_ram_io=1, sel_o_i=1, rdata=8'h00.
- Output port write and readback: we_oport0=1, wdata=8'hA5 for one cycle. Required: oport0=8'hA5 after that edge and thereafter. With sel_ram_io=1, sel_o_i=0, rdata=8'hA5. With sel_ram_io=0 and ram_rdata=8'h3C, rdata=8'h3C.
- Debounce latency: DEBOUNCE_CYCLES=4, set iport0_pin from 8'h00 to 8'h5A before edge 0 and hold. Required: stable reads 8'h00 through edge 5, reads 8'h5A after edge 6, and iport0_changed rises after edge 6.
- Glitch rejection: pin 8'h00 to 8'hFF for 3 cycles, then back to 8'h00. Required: stable stays 8'h00, iport0_changed stays 0, cnt returns to 0. Also apply a pin that toggles every cycle for 20 cycles: no update.
- Acknowledge: with iport0_changed=1, pulse we_iport0. Required: flag 0 next cycle. Then schedule a new stable update on the same edge as we_iport0. Required: flag remains 1.
- Reset mid-operation: assert rst_n=0 two cycles into a debounce of 8'h77 after oport0=8'h12 was written. Required: immediately oport0=8'h00, flag=0, stable=0. After release with pin held at 8'h77, stable=8'h77 after 2+DEBOUNCE_CYCLES edges.
